// File: rtl/gol_pkg.sv
// Package gol_pkg: shared types and helpers for the Game-of-Life display stage.
//   GRID_W       width of one generation (16x16 grid, row-major, row 0 in the MSBs)
//   ROW_W        width of one matrix row
//   POP_W        width needed to count every live cell (0..GRID_W)
//   scan_state_t row-scan state machine encoding
//   row_of()     extracts row r of a grid; bit 15 of the result is the leftmost column
package gol_pkg;

  localparam int GRID_W = 256;
  localparam int ROW_W  = 16;
  localparam int POP_W  = $clog2(GRID_W + 1);

  typedef enum logic [1:0] {
    SCAN_IDLE,
    SCAN_BLANK,
    SCAN_DRIVE
  } scan_state_t;

  // Row 0 occupies the top 16 bits of the grid, row 15 the bottom 16.
  function automatic logic [ROW_W-1:0] row_of(input logic [GRID_W-1:0] grid, input int r);
    return grid[GRID_W-1-ROW_W*r -: ROW_W];
  endfunction

endpackage

// File: rtl/gol_matrix_scan_if.sv
// Interface gol_matrix_scan_if: bundle between the generation producer and the matrix scanner.
//   grid_in     generation to display (row r = grid_in[255-16r -: 16])
//   grid_valid  1-cycle strobe, grid_in holds a new generation
//   row_sel     one-hot active-high row drive
//   col_data    column data for the selected row (1 = lit)
//   frame_done  1-cycle pulse after the last row's dwell
//   frame_drop  1-cycle pulse when an unshown pending generation is overwritten
//   pop_count   live cells in the display buffer (0 unless GOL_SCAN_POPCOUNT_EN)
// Modports: master = generator side, slave = scanner side.
interface gol_matrix_scan_if;
  import gol_pkg::*;

  logic [GRID_W-1:0] grid_in;
  logic              grid_valid;
  logic [ROW_W-1:0]  row_sel;
  logic [ROW_W-1:0]  col_data;
  logic              frame_done;
  logic              frame_drop;
  logic [POP_W-1:0]  pop_count;

  modport master (
    output grid_in, grid_valid,
    input  row_sel, col_data, frame_done, frame_drop, pop_count
  );

  modport slave (
    input  grid_in, grid_valid,
    output row_sel, col_data, frame_done, frame_drop, pop_count
  );

endinterface

// File: rtl/gol_popcount.sv
// Module gol_popcount: registered population count of a full grid.
//   clk    clock
//   reset  asynchronous, active-high
//   grid   256-bit grid to count
//   count  number of 1s in grid, registered (valid one cycle after grid changes)
module gol_popcount
  import gol_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] grid,
  output logic [POP_W-1:0]  count
);

  logic [POP_W-1:0] sum;

  always_comb begin
    sum = '0;
    for (int i = 0; i < GRID_W; i++) begin
      sum = sum + POP_W'(grid[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= sum;
    end
  end

endmodule

// File: rtl/gol_matrix_scan.sv
// Module gol_matrix_scan: double-buffered row-multiplexed LED matrix scanner.
//   clk    clock
//   reset  asynchronous, active-high
//   bus    gol_matrix_scan_if.slave (grid_in/grid_valid in; row_sel, col_data,
//          frame_done, frame_drop, pop_count out)
// New generations land in a pending buffer while scanning and are promoted to
// the display buffer only at the frame boundary, so a frame never tears.
// Each row gets BLANK_CYCLES of all-off followed by DWELL_CYCLES of drive.
// Optional feature: define GOL_SCAN_POPCOUNT_EN to report the live-cell count
// of the display buffer on pop_count; otherwise pop_count is tied to 0.
module gol_matrix_scan #(
  parameter int ROWS         = 16,
  parameter int COLS         = 16,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input logic             clk,
  input logic             reset,
  gol_matrix_scan_if.slave bus
);
  import gol_pkg::*;

  localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1;

  scan_state_t       state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [RW-1:0]     row, row_n;
  logic [GRID_W-1:0] disp, pend;
  logic              pend_valid;
  logic [COLS-1:0]   row_bits;
  logic              blank_end, drive_end, frame_end;
  logic [ROW_W-1:0]  row_sel_q, col_data_q;
  logic              frame_done_q, frame_drop_q;
  logic [POP_W-1:0]  pop_q;

  assign blank_end = (cnt == CW'(BLANK_CYCLES - 1));
  assign drive_end = (cnt == CW'(DWELL_CYCLES - 1));
  // Last cycle of the last row's dwell: the only point where display may swap.
  assign frame_end = (state == SCAN_DRIVE) && drive_end && (row == RW'(ROWS - 1));
  assign row_bits  = row_of(disp, int'(row));

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    row_n   = row;
    case (state)
      SCAN_IDLE: begin
        cnt_n = '0;
        if (bus.grid_valid) state_n = SCAN_BLANK;
      end
      SCAN_BLANK: begin
        if (blank_end) begin
          state_n = SCAN_DRIVE;
          cnt_n   = '0;
        end
      end
      SCAN_DRIVE: begin
        if (drive_end) begin
          state_n = SCAN_BLANK;
          cnt_n   = '0;
          row_n   = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
        end
      end
      default: begin
        state_n = SCAN_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SCAN_IDLE;
      cnt   <= '0;
      row   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      row   <= row_n;
    end
  end

  // A generation arriving on the frame boundary bypasses the pending buffer
  // and goes straight to display, discarding any older pending one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp         <= '0;
      pend         <= '0;
      pend_valid   <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      frame_drop_q <= 1'b0;
      if (state == SCAN_IDLE) begin
        if (bus.grid_valid) disp <= bus.grid_in;
      end else if (frame_end) begin
        if (bus.grid_valid) begin
          disp         <= bus.grid_in;
          pend_valid   <= 1'b0;
          frame_drop_q <= pend_valid;
        end else if (pend_valid) begin
          disp       <= pend;
          pend_valid <= 1'b0;
        end
      end else if (bus.grid_valid) begin
        pend         <= bus.grid_in;
        pend_valid   <= 1'b1;
        frame_drop_q <= pend_valid;
      end
    end
  end

  // Outputs are registered from the next state so they change on the first
  // cycle of each state. Row does not advance on BLANK->DRIVE, so the current
  // row and display buffer are the ones that will be driven.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      row_sel_q    <= '0;
      col_data_q   <= '0;
      frame_done_q <= frame_end;
      if (state_n == SCAN_DRIVE) begin
        row_sel_q  <= ROW_W'(1) << row;
        col_data_q <= row_bits;
      end
    end
  end

`ifdef GOL_SCAN_POPCOUNT_EN
  gol_popcount u_popcount (
    .clk   (clk),
    .reset (reset),
    .grid  (disp),
    .count (pop_q)
  );
`else
  assign pop_q = '0;
`endif

  assign bus.row_sel    = row_sel_q;
  assign bus.col_data   = col_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_drop = frame_drop_q;
  assign bus.pop_count  = pop_q;

endmodule
